// File: rtl/rob_pkg.sv
// Shared ROB definitions: entry count, tag type and the per-entry record.
// Result width comes from the global `XLEN define (32 unless set by the build).
// Imported by rob.sv.
`ifndef XLEN
`define XLEN 32
`endif

package rob_pkg;

  localparam int ROB_SZ    = 8;
  localparam int ROB_TAG_W = $clog2(ROB_SZ);
  localparam int REG_W     = 5;

  typedef logic [ROB_TAG_W-1:0] ROB_TAG;

  typedef struct packed {
    logic             valid;
    logic             ready;
    logic [REG_W-1:0] dest_reg;
    logic [`XLEN-1:0] value;
  } ROB_ENTRY;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate at tail, out-of-order CDB completion, in-order retire at head.
// Latency: dispatch and CDB writes take effect on the next edge; retire_valid is combinational from head.
// Backpressure: dispatch_ready drops when all entries are in use; a retire in that cycle does not free a slot.
//
// Ports:
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   dispatch_valid/_dest_reg         allocate one entry; dispatch_ready/dispatch_tag report slot and tag
//   cdb_valid/_tag/_value            completion broadcast
//   flush                            discard all entries
//   retire_valid/_tag/_dest_reg/_value  head entry commit
//   count                            number of valid entries
// Optional feature: define ROB_RETIRE_BYPASS_EN to let a CDB write to a not-ready head retire in the same cycle.
module rob #(
  parameter int ROB_SZ = rob_pkg::ROB_SZ,
  localparam int TAG_W = $clog2(ROB_SZ),
  localparam int CNT_W = $clog2(ROB_SZ + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_valid,
  input  logic [4:0]       dispatch_dest_reg,
  output logic             dispatch_ready,
  output logic [TAG_W-1:0] dispatch_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [`XLEN-1:0] cdb_value,
  input  logic             flush,
  output logic             retire_valid,
  output logic [TAG_W-1:0] retire_tag,
  output logic [4:0]       retire_dest_reg,
  output logic [`XLEN-1:0] retire_value,
  output logic [CNT_W-1:0] count
);

  import rob_pkg::*;

  ROB_ENTRY         rob_q [ROB_SZ];
  ROB_ENTRY         rob_d [ROB_SZ];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  ROB_ENTRY head_ent;
  logic     not_full;
  logic     accept;
  logic     cdb_hit;
  logic     bypass_hit;
  logic     retire;

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    if (p == TAG_W'(ROB_SZ - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign head_ent = rob_q[head_q];
  assign not_full = (count_q < CNT_W'(ROB_SZ));

  // During reset the block is about to be empty, so advertise a free slot.
  assign dispatch_ready = reset || not_full;
  assign dispatch_tag   = tail_q;
  assign accept         = dispatch_valid && not_full && !flush && !reset;

  // Only a valid, still-pending entry accepts a result; later writes cannot overwrite it.
  // A dispatch into the same slot wins: that slot is invalid beforehand, but guard it explicitly.
  assign cdb_hit = cdb_valid && rob_q[cdb_tag].valid && !rob_q[cdb_tag].ready
                   && !(accept && (cdb_tag == tail_q));

`ifdef ROB_RETIRE_BYPASS_EN
  assign bypass_hit = cdb_valid && head_ent.valid && !head_ent.ready && (cdb_tag == head_q);
`else
  assign bypass_hit = 1'b0;
`endif

  assign retire = !reset && !flush && head_ent.valid && (head_ent.ready || bypass_hit);

  assign retire_valid    = retire;
  assign retire_tag      = head_q;
  assign retire_dest_reg = head_ent.dest_reg;
  assign retire_value    = bypass_hit ? cdb_value : head_ent.value;
  assign count           = count_q;

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      // Payloads are left in place; only validity matters after a flush.
      for (int i = 0; i < ROB_SZ; i++) rob_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_hit) begin
        rob_d[cdb_tag].ready = 1'b1;
        rob_d[cdb_tag].value = cdb_value;
      end
      if (retire) begin
        rob_d[head_q].valid = 1'b0;
        head_d              = ptr_inc(head_q);
      end
      if (accept) begin
        rob_d[tail_q].valid    = 1'b1;
        rob_d[tail_q].ready    = 1'b0;
        rob_d[tail_q].dest_reg = dispatch_dest_reg;
        tail_d                 = ptr_inc(tail_q);
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(retire);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ROB_SZ; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
`ifndef XLEN
`define XLEN 32
`endif

module tb_rob;

  logic             clock = 1'b0;
  logic             reset;
  logic             dispatch_valid;
  logic [4:0]       dispatch_dest_reg;
  logic             dispatch_ready;
  logic [2:0]       dispatch_tag;
  logic             cdb_valid;
  logic [2:0]       cdb_tag;
  logic [`XLEN-1:0] cdb_value;
  logic             flush;
  logic             retire_valid;
  logic [2:0]       retire_tag;
  logic [4:0]       retire_dest_reg;
  logic [`XLEN-1:0] retire_value;
  logic [3:0]       count;

  rob dut (
    .clock             (clock),
    .reset             (reset),
    .dispatch_valid    (dispatch_valid),
    .dispatch_dest_reg (dispatch_dest_reg),
    .dispatch_ready    (dispatch_ready),
    .dispatch_tag      (dispatch_tag),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_value         (cdb_value),
    .flush             (flush),
    .retire_valid      (retire_valid),
    .retire_tag        (retire_tag),
    .retire_dest_reg   (retire_dest_reg),
    .retire_value      (retire_value),
    .count             (count)
  );

  always #5 clock = ~clock;

  // Reference: program-ordered list of in-flight instructions.
  typedef struct {
    int               tag;
    int               dest;
    bit               rdy;
    logic [`XLEN-1:0] val;
  } ment_t;

  ment_t mq[$];
  int    alloc_tag = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit dv, input int dest, input bit cv, input int ctag,
                       input logic [`XLEN-1:0] cval, input bit fl, input bit rst);
    logic [31:0] d;
    logic [31:0] t;
    d = dest;
    t = ctag;
    dispatch_valid    = dv;
    dispatch_dest_reg = d[4:0];
    cdb_valid         = cv;
    cdb_tag           = t[2:0];
    cdb_value         = cval;
    flush             = fl;
    reset             = rst;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, '0, 0, 0);
  endtask

  // Inputs are already applied (after a falling edge). Compare against the
  // reference, then advance the reference across the rising edge.
  task automatic step();
    int  sz;
    int  head;
    bit  byp;
    bit  exp_rv;
    bit  acc;
    #1;
    sz   = mq.size();
    head = (sz > 0) ? mq[0].tag : alloc_tag;
    byp  = 1'b0;
`ifdef ROB_RETIRE_BYPASS_EN
    byp = (sz > 0) && !mq[0].rdy && cdb_valid && (int'(cdb_tag) == mq[0].tag);
`endif
    exp_rv = !reset && !flush && (sz > 0) && (mq[0].rdy || byp);
    acc    = dispatch_valid && (sz < 8);

    check("dispatch_ready", dispatch_ready, reset || (sz < 8));
    check("dispatch_tag", dispatch_tag, alloc_tag);
    check("count", count, sz);
    check("retire_valid", retire_valid, exp_rv);
    check("retire_tag", retire_tag, head);
    if (sz > 0) check("retire_dest_reg", retire_dest_reg, mq[0].dest);
    if (exp_rv) check("retire_value", retire_value, byp ? cdb_value : mq[0].val);

    @(posedge clock);
    if (reset || flush) begin
      mq.delete();
      alloc_tag = 0;
    end else begin
      if (cdb_valid) begin
        foreach (mq[i]) begin
          if (mq[i].tag == int'(cdb_tag) && !mq[i].rdy) begin
            mq[i].rdy = 1'b1;
            mq[i].val = cdb_value;
          end
        end
      end
      if (exp_rv) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{tag: alloc_tag, dest: int'(dispatch_dest_reg), rdy: 1'b0, val: '0});
        alloc_tag = (alloc_tag + 1) % 8;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    bit found;
    int dv, cv, ct, fl, rs;

    // Power-up: state is unknown until the first reset edge.
    drive(0, 0, 0, 0, '0, 0, 1);
    @(posedge clock);
    @(negedge clock);

    // Post-reset state.
    idle(); #1;
    check("rst_count", count, 0);
    check("rst_dispatch_tag", dispatch_tag, 0);
    check("rst_dispatch_ready", dispatch_ready, 1);
    check("rst_retire_valid", retire_valid, 0);
    step();

    // Outputs while reset is asserted.
    drive(0, 0, 0, 0, '0, 0, 1); #1;
    check("in_rst_retire_valid", retire_valid, 0);
    check("in_rst_dispatch_ready", dispatch_ready, 1);
    step();

    // Dispatch r5,r6,r7 -> tags 0,1,2.
    for (int i = 0; i < 3; i++) begin
      drive(1, 5 + i, 0, 0, '0, 0, 0); #1;
      check("seq_dispatch_tag", dispatch_tag, i);
      step();
    end
    idle(); #1;
    check("seq_count3", count, 3);
    check("seq_retire_valid0", retire_valid, 0);
    step();

    // Out-of-order completion, in-order retire.
    drive(0, 0, 1, 1, 'h22, 0, 0); step();
    drive(0, 0, 1, 0, 'h11, 0, 0); #1;
`ifdef ROB_RETIRE_BYPASS_EN
    check("ooo_r5_valid", retire_valid, 1);
    check("ooo_r5_dest", retire_dest_reg, 5);
    check("ooo_r5_value", retire_value, 'h11);
    step();
`else
    check("ooo_no_same_cycle", retire_valid, 0);
    step();
    idle(); #1;
    check("ooo_r5_valid", retire_valid, 1);
    check("ooo_r5_dest", retire_dest_reg, 5);
    check("ooo_r5_value", retire_value, 'h11);
    step();
`endif
    idle(); #1;
    check("ooo_r6_valid", retire_valid, 1);
    check("ooo_r6_dest", retire_dest_reg, 6);
    check("ooo_r6_value", retire_value, 'h22);
    step();

    // Fill, overflow attempt, retire and tail wrap.
    drive(0, 0, 0, 0, '0, 0, 1); step();
    for (int i = 0; i < 8; i++) begin
      drive(1, 10 + i, 0, 0, '0, 0, 0); step();
    end
    idle(); #1;
    check("full_ready", dispatch_ready, 0);
    check("full_count", count, 8);
    step();
    drive(1, 30, 0, 0, '0, 0, 0); step();
    idle(); #1;
    check("full_drop_count", count, 8);
    step();
    drive(0, 0, 1, 0, 'hAB, 0, 0); step();
    idle(); step();
    idle(); #1;
    check("wrap_count", count, 7);
    check("wrap_ready", dispatch_ready, 1);
    check("wrap_tag", dispatch_tag, 0);
    step();
    drive(1, 31, 0, 0, '0, 0, 0); step();
    idle(); #1;
    check("wrap_refill_count", count, 8);
    step();

    // Write to invalid entry ignored; first result kept.
    drive(0, 0, 0, 0, '0, 0, 1); step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1 + i, 0, 0, '0, 0, 0); step();
    end
    drive(0, 0, 1, 4, 'h99, 0, 0); step();
    idle(); #1;
    check("inv_cdb_count", count, 3);
    check("inv_cdb_retire", retire_valid, 0);
    step();
    drive(0, 0, 1, 1, 'h55, 0, 0); step();
    drive(0, 0, 1, 1, 'hBAD, 0, 0); step();
    drive(0, 0, 1, 0, 'h1, 0, 0); step();
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(); #1;
      if (!found && retire_valid && retire_tag == 3'd1) begin
        check("keep_first_value", retire_value, 'h55);
        found = 1'b1;
      end
      step();
    end
    check("keep_first_seen", found, 1);

    // Flush with concurrent dispatch and CDB.
    drive(0, 0, 0, 0, '0, 0, 1); step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 20 + i, 0, 0, '0, 0, 0); step();
    end
    drive(1, 9, 1, 0, 'h5, 1, 0); #1;
    check("flush_retire_valid", retire_valid, 0);
    step();
    idle(); #1;
    check("flush_count", count, 0);
    check("flush_retire_after", retire_valid, 0);
    check("flush_tag", dispatch_tag, 0);
    step();

    // Head tag 3 completion latency.
    drive(0, 0, 0, 0, '0, 0, 1); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 12 + i, 0, 0, '0, 0, 0); step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, i, i + 1, 0, 0); step();
    end
    for (int i = 0; i < 3; i++) begin
      idle(); step();
    end
    idle(); #1;
    check("lat_head3", retire_tag, 3);
    check("lat_head3_notready", retire_valid, 0);
    check("lat_count1", count, 1);
    step();
    drive(0, 0, 1, 3, 'h7, 0, 0); #1;
`ifdef ROB_RETIRE_BYPASS_EN
    check("lat_bypass_valid", retire_valid, 1);
    check("lat_bypass_value", retire_value, 'h7);
    step();
    idle(); #1;
    check("lat_bypass_empty", count, 0);
    step();
`else
    check("lat_same_cycle", retire_valid, 0);
    step();
    idle(); #1;
    check("lat_next_valid", retire_valid, 1);
    check("lat_next_value", retire_value, 'h7);
    step();
`endif

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      dv = ($urandom % 3) != 0;
      cv = $urandom % 2;
      if (mq.size() > 0 && ($urandom % 3) != 0)
        ct = mq[$urandom_range(mq.size() - 1, 0)].tag;
      else
        ct = $urandom % 8;
      fl = ($urandom % 64) == 0;
      rs = ($urandom % 200) == 0;
      drive(dv[0], $urandom % 32, cv[0], ct, $urandom, fl[0], rs[0]);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
